// File: rtl/rs232_pkg.sv
// rs232_pkg: shared FSM state encoding, parity modes and baud divisor helper for the RS232 sender
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        BRKSTOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int baud_divisor(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/rs232_fifo.sv
// rs232_fifo: synchronous FIFO, 2**LOG2 entries of WIDTH bits, head word always presented on dout
// Ports: clock, reset (async, active-high); push/din write side; pop/dout read side;
//        full, empty flags; level = occupancy (LOG2+1 bits).
module rs232_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    level
);

    logic [WIDTH-1:0] r_mem [2**LOG2];
    logic [LOG2-1:0]  r_wr;
    logic [LOG2-1:0]  r_rd;
    logic [LOG2:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && !empty;
    // A push while full is accepted only when a pop frees the slot in the same cycle.
    assign w_push = push && (!full || w_pop);
    assign full   = r_level[LOG2];
    assign empty  = r_level == '0;
    assign level  = r_level;
    assign dout   = r_mem[r_rd];

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + {{LOG2{1'b0}}, w_push} - {{LOG2{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/rs232_send_fifo.sv
// rs232_send_fifo: FIFO-buffered UART transmitter with configurable frame and RTS_n flow control
// Ports: clock, reset (async, active-high); data/valid/ready enqueue handshake;
//        txd serial line (idle high); rts_n peer flow control (active low, asynchronous);
//        busy = frame in progress; level = FIFO occupancy.
// Build option RS232_SEND_BREAK_EN adds input brk, which holds the line low (break) from IDLE.
module rs232_send_fifo #(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 12000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_LOG2  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 txd,
    input  logic                 rts_n,
`ifdef RS232_SEND_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 busy,
    output logic [FIFO_LOG2:0]   level
);

    import rs232_pkg::*;

    localparam int             DIVISOR   = baud_divisor(CLOCK_FREQ, BAUD_RATE);
    localparam int             CW        = $clog2(DIVISOR);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(DIVISOR - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           PAR_INV   = (PARITY == PARITY_ODD);

    if (DIVISOR < 2) begin : g_div_chk
        $error("rs232_send_fifo: DIVISOR must be >= 2");
    end

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_txd;
    logic                 r_rts_m;
    logic                 r_rts;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_brk;
    logic                 w_pop;

`ifdef RS232_SEND_BREAK_EN
    assign w_brk = brk;
`else
    assign w_brk = 1'b0;
`endif

    rs232_fifo #(.WIDTH(DATA_BITS), .LOG2(FIFO_LOG2)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (valid),
        .din   (data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign ready       = !w_full;
    assign txd         = r_txd;
    assign busy        = r_state != IDLE;
    assign w_tick      = r_cnt == DIV_LAST;
    assign w_last_stop = r_state == STOP && w_tick && r_bit == STOP_LAST;
    // Popping the head is the IDLE->START (or STOP->START back-to-back) decision itself.
    assign w_pop       = !w_empty && !r_rts && !w_brk && (r_state == IDLE || w_last_stop);

    // Reset to 1 so nothing is sent until the peer has been seen low for two clocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rts_m <= 1'b1;
            r_rts   <= 1'b1;
        end else begin
            r_rts_m <= rts_n;
            r_rts   <= r_rts_m;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            // Held at 0 in IDLE and cleared on every tick, so each state starts a fresh bit period.
            r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            if (w_pop) begin
                r_state <= START;
                r_txd   <= 1'b0;
                r_shift <= w_head;
                r_par   <= ^w_head ^ PAR_INV;
            end else begin
                case (r_state)
`ifdef RS232_SEND_BREAK_EN
                    IDLE: if (w_brk) begin
                        r_state <= BREAK;
                        r_txd   <= 1'b0;
                    end
                    BREAK: if (!w_brk) begin
                        r_state <= BRKSTOP;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_txd   <= 1'b1;
                    end
                    BRKSTOP: if (w_tick) begin
                        if (r_bit != STOP_LAST) r_bit <= r_bit + 1'b1;
                        else r_state <= IDLE;
                    end
`endif
                    START: if (w_tick) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                    DATA: if (w_tick) begin
                        if (r_bit != DATA_LAST) begin
                            r_bit   <= r_bit + 1'b1;
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end else if (PARITY != PARITY_NONE) begin
                            r_state <= rs232_pkg::PARITY;
                            r_txd   <= r_par;
                        end else begin
                            r_state <= STOP;
                            r_bit   <= '0;
                            r_txd   <= 1'b1;
                        end
                    end
                    rs232_pkg::PARITY: if (w_tick) begin
                        r_state <= STOP;
                        r_bit   <= '0;
                        r_txd   <= 1'b1;
                    end
                    STOP: if (w_tick) begin
                        if (r_bit != STOP_LAST) r_bit <= r_bit + 1'b1;
`ifdef RS232_SEND_BREAK_EN
                        else if (w_brk) begin
                            r_state <= BREAK;
                            r_txd   <= 1'b0;
                        end
`endif
                        else r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rs232_send_fifo.sv
// tb_rs232_send_fifo: directed self-checking bench for rs232_send_fifo (16 clocks per bit)
module tb_rs232_send_fifo;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       rts_n   = 1'b0;
    logic [7:0] data    = '0;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic       valid_c = 1'b0;
`ifdef RS232_SEND_BREAK_EN
    logic       brk     = 1'b0;
`endif
    logic       txd_a, txd_b, txd_c;
    logic       ready_a, ready_b, ready_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] level_a;
    logic [4:0] level_b, level_c;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int          sel;
        logic [7:0]  din;
        int          nbits;
        logic [11:0] frame;
    } vec_t;
    vec_t vecs [8];

    always #5 clock = ~clock;

    // A: 8N1, 4-deep FIFO
    rs232_send_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_LOG2(2)) dut_a (
        .clock(clock), .reset(reset), .data(data), .valid(valid_a), .ready(ready_a), .txd(txd_a), .rts_n(rts_n),
`ifdef RS232_SEND_BREAK_EN
        .brk(brk),
`endif
        .busy(busy_a), .level(level_a));

    // B: 8E2
    rs232_send_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_LOG2(4)) dut_b (
        .clock(clock), .reset(reset), .data(data), .valid(valid_b), .ready(ready_b), .txd(txd_b), .rts_n(rts_n),
`ifdef RS232_SEND_BREAK_EN
        .brk(brk),
`endif
        .busy(busy_b), .level(level_b));

    // C: 8O1
    rs232_send_fifo #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_LOG2(4)) dut_c (
        .clock(clock), .reset(reset), .data(data), .valid(valid_c), .ready(ready_c), .txd(txd_c), .rts_n(rts_n),
`ifdef RS232_SEND_BREAK_EN
        .brk(brk),
`endif
        .busy(busy_c), .level(level_c));

    function automatic logic txd_of(input int s);
        return s == 0 ? txd_a : s == 1 ? txd_b : txd_c;
    endfunction

    function automatic logic busy_of(input int s);
        return s == 0 ? busy_a : s == 1 ? busy_b : busy_c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int s, input logic [7:0] d);
        data    = d;
        valid_a = s == 0;
        valid_b = s == 1;
        valid_c = s == 2;
        @(negedge clock);
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    // 8N1 receiver on instance A; the current negedge counts as a possible start-bit sample.
    task automatic recv_a(input string name, input logic [7:0] exp);
        int         n;
        logic [7:0] got;
        n   = 0;
        got = '0;
        while (txd_a !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            chk({name, "_timeout"}, txd_a, 0);
            return;
        end
        repeat (8) @(negedge clock);
        chk({name, "_start"}, txd_a, 0);
        for (int k = 0; k < 8; k++) begin
            repeat (16) @(negedge clock);
            got[k] = txd_a;
        end
        repeat (16) @(negedge clock);
        chk({name, "_stop"}, txd_a, 1);
        chk(name, got, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        // frame bit 0 = start bit, then data LSB first, parity, stop bit(s)
        vecs[0] = '{0, 8'hA5, 10, 12'h34A};
        vecs[1] = '{0, 8'h00, 10, 12'h200};
        vecs[2] = '{0, 8'hFF, 10, 12'h3FE};
        vecs[3] = '{0, 8'h3C, 10, 12'h278};
        vecs[4] = '{1, 8'h07, 12, 12'hE0E};
        vecs[5] = '{1, 8'h03, 12, 12'hC06};
        vecs[6] = '{2, 8'h07, 11, 12'h40E};
        vecs[7] = '{2, 8'h00, 11, 12'h600};

        repeat (2) @(negedge clock);
        chk("rst_txd_a", txd_a, 1);
        chk("rst_ready_a", ready_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_level_a", level_a, 0);
        chk("rst_txd_b", txd_b, 1);
        chk("rst_ready_b", ready_b, 1);
        chk("rst_level_b", level_b, 0);
        chk("rst_txd_c", txd_c, 1);
        chk("rst_ready_c", ready_c, 1);
        chk("rst_level_c", level_c, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Single frames: exact 2-clock latency, every bit at its midpoint, busy width.
        for (int i = 0; i < 8; i++) begin
            put(vecs[i].sel, vecs[i].din);
            chk($sformatf("v%0d_lat1", i), txd_of(vecs[i].sel), 1);
            @(negedge clock);
            chk($sformatf("v%0d_lat2", i), txd_of(vecs[i].sel), 0);
            nb = 0;
            for (int c = 0; c < vecs[i].nbits * 16 + 4; c++) begin
                if (busy_of(vecs[i].sel)) nb++;
                if (c % 16 == 8 && c / 16 < vecs[i].nbits)
                    chk($sformatf("v%0d_bit%0d", i, c / 16), txd_of(vecs[i].sel), vecs[i].frame[c / 16]);
                @(negedge clock);
            end
            chk($sformatf("v%0d_busy_len", i), nb, vecs[i].nbits * 16);
        end

        // Flow control: hold, release through synchroniser, back-to-back, mid-frame raise.
        rts_n = 1'b1;
        repeat (3) @(negedge clock);
        data = 8'h11; valid_a = 1'b1;
        @(negedge clock);
        data = 8'h22;
        @(negedge clock);
        data = 8'h33;
        @(negedge clock);
        valid_a = 1'b0;
        repeat (20) @(negedge clock);
        chk("hold_txd", txd_a, 1);
        chk("hold_level", level_a, 3);
        chk("hold_busy", busy_a, 0);
        rts_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("sync_still_high", txd_a, 1);
        @(negedge clock);
        chk("sync_start", txd_a, 0);
        chk("b2b_level2", level_a, 2);
        repeat (159) @(negedge clock);
        chk("f1_stop", txd_a, 1);
        @(negedge clock);
        chk("f2_no_gap", txd_a, 0);
        chk("b2b_level1", level_a, 1);
        repeat (40) @(negedge clock);
        chk("f2_bit1", txd_a, 1);
        rts_n = 1'b1;
        repeat (120) @(negedge clock);
        chk("f3_held_txd", txd_a, 1);
        chk("f3_held_busy", busy_a, 0);
        chk("f3_held_level", level_a, 1);
        rts_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("f3_start", txd_a, 0);
        chk("drain_level", level_a, 0);
        recv_a("f3", 8'h33);
        repeat (12) @(negedge clock);
        chk("f3_done_busy", busy_a, 0);

        // Full FIFO: 5th write dropped, then push+pop while full keeps level.
        rts_n = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready%0d", i), ready_a, i < 4);
            data = 8'(i + 1);
            valid_a = 1'b1;
            @(negedge clock);
        end
        valid_a = 1'b0;
        chk("full_ready", ready_a, 0);
        chk("full_level", level_a, 4);
        rts_n = 1'b0;
        repeat (2) @(negedge clock);
        data = 8'h99; valid_a = 1'b1;
        @(negedge clock);
        valid_a = 1'b0;
        chk("pp_level", level_a, 4);
        chk("pp_txd", txd_a, 0);
        recv_a("q1", 8'h01);
        recv_a("q2", 8'h02);
        recv_a("q3", 8'h03);
        recv_a("q4", 8'h04);
        recv_a("q5", 8'h99);
        repeat (12) @(negedge clock);
        chk("q_empty", level_a, 0);

        // Asynchronous reset in the middle of DATA.
        put(0, 8'h00);
        put(0, 8'h00);
        repeat (40) @(negedge clock);
        chk("pre_rst_txd", txd_a, 0);
        chk("pre_rst_busy", busy_a, 1);
        chk("pre_rst_level", level_a, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_txd", txd_a, 1);
        chk("arst_busy", busy_a, 0);
        chk("arst_level", level_a, 0);
        chk("arst_ready", ready_a, 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        put(0, 8'h5A);
        recv_a("post_rst", 8'h5A);
        repeat (12) @(negedge clock);

`ifdef RS232_SEND_BREAK_EN
        begin
            int lo;
            int hi;
            rts_n = 1'b1;
            repeat (3) @(negedge clock);
            put(0, 8'hC3);
            brk   = 1'b1;
            rts_n = 1'b0;
            lo = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (txd_a === 1'b0) lo++;
            end
            brk = 1'b0;
            hi = 0;
            @(negedge clock);
            while (txd_a === 1'b1 && hi < 100) begin
                hi++;
                @(negedge clock);
            end
            chk("brk_low_len", lo, 40);
            chk("brk_stop_min", hi >= 16 && hi < 100, 1);
            recv_a("brk_data", 8'hC3);
            repeat (12) @(negedge clock);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
